// File: rtl/ir_sequencer_if.sv
// ir_sequencer_if: control/status bundle between the instruction sequencer
// and its neighbours (register file and instruction source).
//   IR_in              load request into the sequencer
//   GPR_in / GPR_out   register-file write / bus-drive strobes
//   GPR_select         register select code for the strobes
//   Rd_1 Rs_1 Rs_2 Rd_2 decoded register fields of the current IR
//   IR_OUT             current IR contents
//   busy done illegal overrun  sequencer status
// The shared 16-bit DATA bus is a plain inout port of the sequencer.
interface ir_sequencer_if;
    logic        IR_in;
    logic        GPR_in;
    logic        GPR_out;
    logic [2:0]  GPR_select;
    logic [2:0]  Rd_1;
    logic [2:0]  Rs_1;
    logic [2:0]  Rs_2;
    logic [2:0]  Rd_2;
    logic [15:0] IR_OUT;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        overrun;

    // sequencer side
    modport master (
        input  IR_in,
        output GPR_in, GPR_out, GPR_select, Rd_1, Rs_1, Rs_2, Rd_2,
        output IR_OUT, busy, done, illegal, overrun
    );

    // register file / instruction source side
    modport slave (
        output IR_in,
        input  GPR_in, GPR_out, GPR_select, Rd_1, Rs_1, Rs_2, Rd_2,
        input  IR_OUT, busy, done, illegal, overrun
    );
endinterface

// File: rtl/ir_sequencer.sv
// ir_sequencer: instruction register plus micro-step sequencer in front of
// the GPR file. Latches an instruction from DATA, decodes its register
// fields and steps the GPR strobes, using temporaries T (and U) to turn
// register-to-register moves into single-direction bus transfers.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   DATA   16-bit shared bus; driven only in drive steps, else high-Z
//   ctl    ir_sequencer_if.master (load request, GPR strobes, fields, status)
// Build option: define IRSEQ_SWAP_EN to implement opcode 0011 (SWP) with the
// second temporary U; otherwise U is not built and 0011 decodes as illegal.
module ir_sequencer (
    input  logic           clk,
    input  logic           reset,
    inout  wire  [15:0]    DATA,
    ir_sequencer_if.master ctl
);
    localparam int unsigned W = 16;

    localparam logic [2:0] SEL_R0  = 3'b000;
    localparam logic [2:0] SEL_R7  = 3'b001;
    localparam logic [2:0] SEL_RD1 = 3'b010;
    localparam logic [2:0] SEL_RS1 = 3'b100;
    localparam logic [2:0] SEL_RS2 = 3'b101;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_T, SRC_U, SRC_IMM} src_t;

    // Everything the bus/register file sees during one step
    typedef struct packed {
        logic       gpr_in;
        logic       gpr_out;
        logic [2:0] sel;
        logic       cap_t;
`ifdef IRSEQ_SWAP_EN
        logic       cap_u;
`endif
        src_t       src;
        logic       last;
    } step_t;

    function automatic step_t decode(input state_t st, input logic [1:0] s,
                                     input logic [3:0] op);
        step_t d;
        d     = '0;
        d.src = SRC_NONE;
        if (st == EXEC) begin
            d.last = 1'b1;
            case (op)
                // MOV / CLR / MVR7: read source into T, then write T to Rd_1
                4'h1, 4'h4, 4'h5: begin
                    if (s == 2'd0) begin
                        d.gpr_out = 1'b1;
                        d.cap_t   = 1'b1;
                        d.last    = 1'b0;
                        d.sel     = (op == 4'h1) ? SEL_RS1 :
                                    (op == 4'h4) ? SEL_R0 : SEL_R7;
                    end else begin
                        d.src    = SRC_T;
                        d.gpr_in = 1'b1;
                        d.sel    = SEL_RD1;
                    end
                end
                4'h2: begin
                    d.src    = SRC_IMM;
                    d.gpr_in = 1'b1;
                    d.sel    = SEL_RD1;
                end
`ifdef IRSEQ_SWAP_EN
                4'h3: begin
                    d.last = (s == 2'd3);
                    case (s)
                        2'd0: begin d.gpr_out = 1'b1; d.cap_t = 1'b1; d.sel = SEL_RS1; end
                        2'd1: begin d.gpr_out = 1'b1; d.cap_u = 1'b1; d.sel = SEL_RS2; end
                        2'd2: begin d.src = SRC_T; d.gpr_in = 1'b1; d.sel = SEL_RS2; end
                        default: begin d.src = SRC_U; d.gpr_in = 1'b1; d.sel = SEL_RS1; end
                    endcase
                end
`endif
                default: ;
            endcase
        end
        return d;
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
`ifdef IRSEQ_SWAP_EN
        return op > 4'h5;
`else
        return (op > 4'h5) || (op == 4'h3);
`endif
    endfunction

    state_t      state, state_d;
    logic [1:0]  step, step_d;
    logic [W-1:0] ir, ir_d, t, t_d, drv_val, drv_val_d;
    step_t       cur_q, nxt;
    logic        busy_q, done_q, illegal_q, overrun_q;
`ifdef IRSEQ_SWAP_EN
    logic [W-1:0] u, u_d;
`endif

    // Next state; strobes are decoded from the next state so they leave a flop
    always_comb begin
        state_d   = state;
        step_d    = step;
        ir_d      = ir;
        t_d       = t;
`ifdef IRSEQ_SWAP_EN
        u_d       = u;
`endif
        drv_val_d = '0;

        case (state)
            IDLE: if (ctl.IR_in) begin
                state_d = EXEC;
                step_d  = 2'd0;
                ir_d    = DATA;
            end
            EXEC: if (cur_q.last) state_d = DONE;
                  else            step_d  = step + 2'd1;
            default: state_d = IDLE;
        endcase

        if (cur_q.cap_t) t_d = DATA;
`ifdef IRSEQ_SWAP_EN
        if (cur_q.cap_u) u_d = DATA;
`endif

        nxt = decode(state_d, step_d, ir_d[15:12]);
        case (nxt.src)
            SRC_T:   drv_val_d = t_d;
`ifdef IRSEQ_SWAP_EN
            SRC_U:   drv_val_d = u_d;
`endif
            SRC_IMM: drv_val_d = {{(W-6){ir_d[5]}}, ir_d[5:0]};
            default: drv_val_d = '0;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            step      <= 2'd0;
            ir        <= '0;
            t         <= '0;
            cur_q     <= '0;
            drv_val   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_d;
            step      <= step_d;
            ir        <= ir_d;
            t         <= t_d;
            cur_q     <= nxt;
            drv_val   <= drv_val_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            illegal_q <= (state_d == DONE) && is_illegal(ir_d[15:12]);
            if (ctl.IR_in && (state != IDLE)) overrun_q <= 1'b1;
        end
    end

`ifdef IRSEQ_SWAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) u <= '0;
        else        u <= u_d;
    end
`endif

    // Bus is driven only in drive steps; reset releases it immediately
    assign DATA = (cur_q.src != SRC_NONE) ? drv_val : {W{1'bz}};

    assign ctl.GPR_in     = cur_q.gpr_in;
    assign ctl.GPR_out    = cur_q.gpr_out;
    assign ctl.GPR_select = cur_q.sel;
    assign ctl.Rd_1       = ir[11:9];
    assign ctl.Rs_1       = ir[8:6];
    assign ctl.Rs_2       = ir[5:3];
    assign ctl.Rd_2       = ir[2:0];
    assign ctl.IR_OUT     = ir;
    assign ctl.busy       = busy_q;
    assign ctl.done       = done_q;
    assign ctl.illegal    = illegal_q;
    assign ctl.overrun    = overrun_q;
endmodule

// File: tb/tb_ir_sequencer.sv
// tb_ir_sequencer: drives instructions into ir_sequencer with a modelled
// register file on the bus and compares the resulting register contents,
// completion timing and status against an instruction-level model.
module tb_ir_sequencer;
    logic clk = 1'b0;
    logic reset;
    wire [15:0] data_bus;

    ir_sequencer_if ctl ();

    ir_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .DATA  (data_bus),
        .ctl   (ctl)
    );

    always #5 clk = ~clk;

`ifdef IRSEQ_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    logic [15:0] rf [8];
    logic [2:0]  rd_idx;
    logic        probe_en;
    logic [15:0] probe_val;
    bit          exp_overrun;
    int          errors = 0;
    int          checks = 0;

    // Register-file read port: drives the selected register while GPR_out
    always_comb begin
        case (ctl.GPR_select)
            3'b000:  rd_idx = 3'd0;
            3'b001:  rd_idx = 3'd7;
            3'b010:  rd_idx = ctl.Rd_1;
            3'b011:  rd_idx = ctl.Rd_2;
            3'b100:  rd_idx = ctl.Rs_1;
            3'b101:  rd_idx = ctl.Rs_2;
            default: rd_idx = 3'd0;
        endcase
    end

    assign data_bus = ctl.GPR_out ? rf[rd_idx] : (probe_en ? probe_val : 16'hzzzz);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Load one instruction, let it run to completion, compare with the model
    task automatic run_instr(input logic [15:0] instr, input bit inject);
        logic [15:0] exp_rf [8];
        logic [3:0]  op;
        logic [2:0]  rd1, rs1, rs2;
        int          n;
        bit          ill;
        bit          seen_done;

        op  = instr[15:12];
        rd1 = instr[11:9];
        rs1 = instr[8:6];
        rs2 = instr[5:3];
        for (int i = 0; i < 8; i++) exp_rf[i] = rf[i];
        n   = 1;
        ill = 1'b0;
        case (op)
            4'h0: n = 1;
            4'h1: begin n = 2; exp_rf[rd1] = rf[rs1]; end
            4'h2: exp_rf[rd1] = {{10{instr[5]}}, instr[5:0]};
            4'h3: if (SWAP_EN) begin
                      n = 4;
                      exp_rf[rs2] = rf[rs1];
                      exp_rf[rs1] = rf[rs2];
                  end else ill = 1'b1;
            4'h4: begin n = 2; exp_rf[rd1] = rf[0]; end
            4'h5: begin n = 2; exp_rf[rd1] = rf[7]; end
            default: ill = 1'b1;
        endcase
        if (inject) exp_overrun = 1'b1;

        seen_done = 1'b0;
        ctl.IR_in = 1'b1;
        probe_en  = 1'b1;
        probe_val = instr;
        for (int cyc = 1; cyc <= 12 && !seen_done; cyc++) begin
            @(posedge clk);
            #1;
            ctl.IR_in = 1'b0;
            probe_en  = 1'b0;
            @(negedge clk);
            check("in_out_excl", 32'(ctl.GPR_in & ctl.GPR_out), 32'd0);
            if (ctl.done) begin
                seen_done = 1'b1;
                check("done_cycle", 32'(cyc), 32'(n + 1));
                check("illegal", 32'(ctl.illegal), 32'(ill));
                check("done_strobes", 32'({ctl.GPR_in, ctl.GPR_out}), 32'd0);
            end else begin
                check("busy", 32'(ctl.busy), 32'd1);
                check("illegal_early", 32'(ctl.illegal), 32'd0);
            end
            if (ctl.GPR_in) rf[rd_idx] = data_bus;
            if (inject && cyc == 1) ctl.IR_in = 1'b1;
        end
        check("done_seen", 32'(seen_done), 32'd1);

        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_busy", 32'(ctl.busy), 32'd0);
        check("idle_done", 32'(ctl.done), 32'd0);
        check("ir_out", 32'(ctl.IR_OUT), 32'(instr));
        check("fields", 32'({ctl.Rd_1, ctl.Rs_1, ctl.Rs_2, ctl.Rd_2}), 32'(instr[11:0]));
        check("overrun", 32'(ctl.overrun), 32'(exp_overrun));
        for (int i = 0; i < 8; i++) check($sformatf("rf%0d", i), 32'(rf[i]), 32'(exp_rf[i]));
    endtask

    // Reset asserted during the first write step of a multi-step instruction
    task automatic reset_mid_op();
        logic [15:0] instr;
        bit          hit;
        instr     = SWAP_EN ? 16'h3070 : 16'h1A80;
        hit       = 1'b0;
        ctl.IR_in = 1'b1;
        probe_en  = 1'b1;
        probe_val = instr;
        for (int cyc = 1; cyc <= 8 && !hit; cyc++) begin
            @(posedge clk);
            #1;
            ctl.IR_in = 1'b0;
            probe_en  = 1'b0;
            @(negedge clk);
            if (ctl.GPR_in) hit = 1'b1;
        end
        check("rst_reach_write", 32'(hit), 32'd1);
        reset     = 1'b0;
        probe_en  = 1'b1;
        probe_val = 16'h5A5A;
        #1;
        check("rst_gpr_in", 32'(ctl.GPR_in), 32'd0);
        check("rst_gpr_out", 32'(ctl.GPR_out), 32'd0);
        check("rst_busy", 32'(ctl.busy), 32'd0);
        check("rst_bus_free", 32'(data_bus), 32'h5A5A);
        check("rst_overrun", 32'(ctl.overrun), 32'd0);
        exp_overrun = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        probe_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_no_done", 32'(ctl.done), 32'd0);
            check("rst_idle", 32'(ctl.busy), 32'd0);
        end
        check("rst_ir", 32'(ctl.IR_OUT), 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        ctl.IR_in   = 1'b0;
        probe_en    = 1'b1;
        probe_val   = 16'h5A5A;
        exp_overrun = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);

        repeat (2) @(negedge clk);
        check("reset_strobes", 32'({ctl.GPR_in, ctl.GPR_out, ctl.GPR_select}), 32'd0);
        check("reset_status", 32'({ctl.busy, ctl.done, ctl.illegal, ctl.overrun}), 32'd0);
        check("reset_ir", 32'(ctl.IR_OUT), 32'd0);
        check("reset_fields", 32'({ctl.Rd_1, ctl.Rs_1, ctl.Rs_2, ctl.Rd_2}), 32'd0);
        check("reset_bus_free", 32'(data_bus), 32'h5A5A);
        reset    = 1'b1;
        probe_en = 1'b0;
        @(negedge clk);

        run_instr(16'h263F, 1'b0);
        rf[2] = 16'h1234;
        run_instr(16'h1A80, 1'b1);
        rf[1] = 16'hAAAA;
        rf[6] = 16'h5555;
        run_instr(16'h3070, 1'b0);
        run_instr(16'hF000, 1'b0);
        run_instr(16'h4E00, 1'b0);
        run_instr(16'h5200, 1'b0);
        run_instr(16'h0000, 1'b0);

        for (int k = 0; k < 60; k++)
            run_instr(16'($urandom), ($urandom_range(0, 7) == 0));

        reset_mid_op();
        run_instr(16'h2C21, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
